// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic {BLANK, DRIVE} scan_state_e;

  // One-hot-low anode vector sized for the largest supported display.
  function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-synchronous double buffering.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEADTIME    = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    wr_ack,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]                cnt;
  logic [IDX_W-1:0]                idx;
  scan_state_e                     state, state_nxt;
  logic [NUM_DIGITS-1:0][3:0]      disp, pend;
  logic                            pend_vld;
  logic                            slot_end, frame_end;
  logic [6:0]                      dec_seg, seg_d;
  logic [NUM_DIGITS-1:0]           an_d, lead_zero;
  logic [MAX_DIGITS-1:0]           an_full;
  logic                            unused_an;

  assign slot_end   = (cnt == CNT_W'(REFRESH_DIV-1));
  assign frame_end  = slot_end && (idx == IDX_W'(NUM_DIGITS-1));
  assign frame_tick = frame_end && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= BLANK;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (cnt == CNT_W'(DEADTIME-1)) state_nxt = DRIVE;
      DRIVE:   if (slot_end)                  state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  // A write on the frame-end cycle lands in pend while disp takes the old pend,
  // so the flag stays set for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= frame_end && pend_vld;
      if (frame_end && pend_vld) disp <= pend;
      if (wr_en) begin
        pend     <= wr_data;
        pend_vld <= 1'b1;
      end else if (frame_end) begin
        pend_vld <= 1'b0;
      end
    end
  end

  hex_to_7seg u_dec (
    .hex (disp[idx]),
    .seg (dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  logic lz_run;
  always_comb begin
    lead_zero = '0;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      lz_run       = lz_run && (disp[i] == 4'h0);
      lead_zero[i] = lz_run && (i != 0);
    end
  end
`else
  assign lead_zero = '0;
`endif

  assign an_full   = an_onehot_low(3'(idx));
  assign unused_an = ^an_full;

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (state == DRIVE) begin
      an_d = an_full[NUM_DIGITS-1:0];
      if (!blank_mask[idx] && !lead_zero[idx]) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: driver predicts, monitor compares every cycle.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DL = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset, wr_en;
  logic [15:0] wr_data;
  logic [3:0]  blank_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        wr_ack, frame_tick;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEADTIME(DL)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .wr_ack     (wr_ack),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ack;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference font, segments {g,f,e,d,c,b,a}, lit = 0.
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int   k;
  int   disp [ND];
  int   pend [ND];
  bit   pflag;

  function automatic bit is_frame_end(input int t);
    return (t % FRAME) == FRAME - 1;
  endfunction

  function automatic bit lz_dark(input int d);
`ifdef SEG_SCAN_LZB_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < ND; j++) if (disp[j] != 0) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  task automatic step(input bit rst, input bit wr, input logic [15:0] data,
                      input logic [3:0] mask);
    exp_t e;
    int c, d;
    logic [3:0] one;
    reset = rst; wr_en = wr; wr_data = data; blank_mask = mask;
    if (rst) begin
      e = '{seg: 7'h7F, an: 4'hF, ack: 1'b0, ft: 1'b0};
      k = 0; pflag = 0;
      for (int i = 0; i < ND; i++) begin disp[i] = 0; pend[i] = 0; end
    end else begin
      c = k % RD;
      d = (k / RD) % ND;
      one = 4'b0001 << d;
      e.an  = (c < DL) ? 4'hF : ~one;
      e.seg = (c < DL || mask[d] || lz_dark(d)) ? 7'h7F : font[disp[d]];
      e.ack = is_frame_end(k) && pflag;
      e.ft  = is_frame_end(k + 1);
      if (is_frame_end(k) && pflag) begin
        for (int i = 0; i < ND; i++) disp[i] = pend[i];
        pflag = 0;
      end
      if (wr) begin
        for (int i = 0; i < ND; i++) pend[i] = int'(data[4*i +: 4]);
        pflag = 1;
      end
      k++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [3:0] mask);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, mask);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s k=%0d actual=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seg", int'(seg), int'(e.seg));
        chk("an", int'(an), int'(e.an));
        chk("wr_ack", int'(wr_ack), int'(e.ack));
        chk("frame_tick", int'(frame_tick), int'(e.ft));
      end
    end
  end

  initial begin : driver
    logic [3:0] m;
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 4'h0);
    idle(40, 4'h0);
    step(0, 1, 16'h12AF, 4'h0);
    idle(80, 4'h0);
    idle(5, 4'h0);
    step(0, 1, 16'h1111, 4'h0);
    idle(3, 4'h0);
    step(0, 1, 16'h2222, 4'h0);
    idle(70, 4'h0);
    while (k % FRAME != FRAME - 1) step(0, 0, 16'h0, 4'h0);
    step(0, 1, 16'h3333, 4'h0);
    idle(80, 4'h0);
    idle(40, 4'b0100);
    step(0, 1, 16'h0005, 4'h0);
    idle(4, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    idle(40, 4'h0);
    step(0, 1, 16'h0005, 4'h0);
    idle(70, 4'h0);
    step(0, 1, 16'h00A5, 4'h0);
    idle(70, 4'h0);
    m = 4'h0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) m = 4'($urandom);
      step($urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0,
           16'($urandom), m);
    end
    idle(2, 4'h0);
    @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one hex_to_7seg decoder across NUM_DIGITS digits and drives active-low segment and anode lines. It holds a double-buffered display register, loaded by a write strobe from the keyboard/CPU side, and commits new data only at frame boundaries so a frame never mixes old and new digits. A dead-time slot between digits suppresses ghosting.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot, including dead time (must be > DEADTIME)
DEADTIME, 500, cycles at the start of each slot with all anodes off

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  one-cycle write strobe for wr_data
wr_data  in  4*NUM_DIGITS  packed hex digits; digit 0 = bits [3:0], the rightmost display position
blank_mask  in  NUM_DIGITS  1 = force digit dark (live, not buffered)
seg  out  7  active-low segments {g,f,e,d,c,b,a}
an  out  NUM_DIGITS  active-low digit enables; one-hot-low or all high
wr_ack  out  1  one-cycle pulse when pending data is committed
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: seg=7'h7F, an=all 1, wr_ack=0, frame_tick=0. Internally: slot counter=0, digit index=0, display reg=0, pending reg=0, pending flag=0, FSM=BLANK.
- Slot counter runs 0..REFRESH_DIV-1 and wraps.
- FSM states:
  - BLANK: counter < DEADTIME; an all 1, seg 7'h7F.
  - DRIVE: counter in DEADTIME..REFRESH_DIV-1.
  - BLANK->DRIVE when counter == DEADTIME-1.
  - DRIVE->BLANK when counter == REFRESH_DIV-1; the digit index increments on the same cycle.
- Digit index wraps from NUM_DIGITS-1 to 0. The cycle where the index wraps is the frame end: frame_tick=1 on that cycle.
- In DRIVE:
  - an[idx]=0, all other an bits 1.
  - seg = decode(display[idx]), or 7'h7F if blank_mask[idx]=1.
- seg and an are registered: they reflect FSM/index state with 1-cycle latency.
- Writes:
  - wr_en captures wr_data into the pending reg and sets the pending flag.
  - Back-to-back writes: last one wins; only one commit per frame.
- Commit: at frame end, if the pending flag is set, display <= pending, pending flag cleared, wr_ack pulses 1 cycle later (registered).
- wr_en on the frame-end cycle: data goes to pending, not to display. The commit uses the previous pending contents; the flag stays set and the new data commits at the next frame end.
- Reset mid-frame: all state returns to reset values next cycle; uncommitted pending data is discarded and no wr_ack is issued.
- blank_mask is sampled every cycle and takes effect with 1-cycle latency.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- With it: in DRIVE, digit idx is additionally blanked when every display nibble from NUM_DIGITS-1 down to idx is 0 and idx != 0. Digit 0 always shows, so 0x0000 displays "0" and 0x00A5 displays "A5".
- Without it: all digits display, including leading zeros.

Decomposition:
- Package seg_pkg: SEG_BLANK=7'h7F; the FSM state enum typedef {BLANK, DRIVE}; a function returning a one-hot-low anode vector from an index.
- Single shared instance of the existing hex_to_7seg decoder fed by a mux on display[idx]; no other sub-module.
- Counter, FSM and buffering live in one module.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, DEADTIME=2.
1. Reset held 3 cycles, then released -> seg=7'h7F, an=4'hF for the first 3 cycles after release (DEADTIME plus 1 latency); then an=4'hE, seg=7'b1000000.
2. Write wr_data=16'h12AF mid-frame -> no display change until frame end (cycle 32). wr_ack pulses at cycle 33. Next frame shows digit0 seg=7'b0001110 (F) and digit3 seg=7'b1111001 (1).
3. Writes 16'h1111 then 16'h2222 within one frame -> single wr_ack; all digits show 7'b0100100.
4. wr_en with 16'h3333 exactly on the frame_tick cycle -> old data shown for one more frame; commit and wr_ack at the following frame end.
5. blank_mask=4'b0100 -> an=4'hB slot shows seg=7'h7F; the other slots are unaffected.
6. Assert reset while a write is pending -> no wr_ack, display reg=0. With SEG_SCAN_LZB_EN and data 16'h0005: an=4'h7, 4'hB and 4'hD slots are dark, and the an=4'hE slot shows 7'b0010010.
